// File: rtl/msg_channel_arbiter_pkg.sv
// Shared types and defaults for the message channel arbiter.
// Grant FSM encoding plus default channel geometry.
package msg_channel_arbiter_pkg;

    localparam int DEFAULT_N_REQ  = 4;
    localparam int DEFAULT_DATA_W = 64;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        HOLD   = ST_HOLD,
        LOCKED = ST_LOCKED
    } arb_state_t;

endpackage

// File: rtl/msg_channel_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after
// ptr (modulo N_REQ). winner falls back to ptr when nothing is requesting.
module msg_channel_arbiter_rr_pick
    import msg_channel_arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  winner
);

    int idx;

    // Walk offsets from farthest to nearest so the closest hit to ptr wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/msg_channel_arbiter.sv
// Round-robin arbiter merging N_REQ valid/ready sources onto one channel.
// Define MSG_ARB_LOCK_EN to hold the channel for multi-beat messages (req_last).
module msg_channel_arbiter
    import msg_channel_arbiter_pkg::*;
#(
    parameter int N_REQ  = DEFAULT_N_REQ,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    output logic [ID_W-1:0]         out_id,
    input  logic                    out_ready
);

    arb_state_t        state_reg, state_next;
    logic [ID_W-1:0]   ptr_reg, ptr_next;
    logic [ID_W-1:0]   owner_reg, owner_next;
    logic              pick_found;
    logic [ID_W-1:0]   pick_winner;
    logic [ID_W-1:0]   sel;
    logic              xfer;
    logic              sel_last;
    logic [DATA_W-1:0] data_arr [N_REQ];

    function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] i);
        return (i == ID_W'(N_REQ - 1)) ? '0 : i + ID_W'(1);
    endfunction

    msg_channel_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr_reg),
        .found  (pick_found),
        .winner (pick_winner)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign data_arr[gi]  = req_data[gi*DATA_W +: DATA_W];
            assign req_ready[gi] = xfer && (sel == ID_W'(gi));
        end
    endgenerate

    assign out_data = data_arr[sel];
    assign out_id   = sel;
    assign xfer     = out_valid && out_ready;

`ifdef MSG_ARB_LOCK_EN
    assign sel_last = req_last[sel];
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign sel_last    = 1'b1;
`endif
    assign out_last = sel_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        sel        = owner_reg;
        out_valid  = req_valid[owner_reg];
        case (state_reg)
            IDLE: begin
                sel       = pick_found ? pick_winner : ptr_reg;
                out_valid = pick_found;
                if (xfer) begin
                    ptr_next = ptr_inc(sel);
                    if (!sel_last) begin
                        state_next = LOCKED;
                        owner_next = sel;
                    end
                end else if (out_valid) begin
                    state_next = HOLD;
                    owner_next = sel;
                end
            end
            HOLD: begin
                if (xfer) begin
                    ptr_next   = ptr_inc(owner_reg);
                    state_next = sel_last ? IDLE : LOCKED;
                end
            end
`ifdef MSG_ARB_LOCK_EN
            LOCKED: begin
                // Gaps between beats keep the lock; only the last beat releases it.
                if (xfer && sel_last) begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
